wyjscia_tx: RTL and testbench
=============================

Name: wyjscia_tx

Overview:
- Output-side counterpart of the fixed-point input stage.
- Accepts 24-bit fixed-point result samples (1.0 = 24'h800000 = 8388608) over a valid/ready handshake and buffers them in a small FIFO.
- Shifts each sample out MSB-first on a framed serial link (sclk/sdata/sfs) toward an external DAC or host.
- Sits at the end of the processing chain, after the arithmetic blocks.

Parameters:
- DATA_W, 24: sample width in bits; also the number of data bits per frame.
- FIFO_DEPTH, 4: FIFO entries; must be a power of two, ≥2.
- CLK_DIV, 4: sclk half-period in clk cycles, ≥1; one bit lasts 2*CLK_DIV clk cycles.

Ports:
- clk  in  1  system clock; everything is on the rising edge.
- rst  in  1  synchronous reset, active-high.
- in_data  in  DATA_W  sample to transmit.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  FIFO can accept a sample; a transfer occurs when in_valid && in_ready at a clk edge.
- sclk  out  1  serial bit clock.
- sdata  out  1  serial data, MSB first.
- sfs  out  1  frame sync; high during the first bit period of each frame.
- busy  out  1  high while a frame (including its gap) is in progress.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of occupied FIFO entries.

Behaviour:
- Reset:
  - sclk, sdata, sfs and busy are 0; fifo_level is 0; FIFO pointers are cleared; FSM is IDLE.
  - in_ready is 0 while rst is high and 1 on the first cycle after.
  - rst asserted mid-frame aborts the frame at that edge and discards all FIFO contents. No partial frame resumes.
- FIFO:
  - in_ready = (fifo_level != FIFO_DEPTH).
  - A push and a pop in the same cycle leave fifo_level unchanged.
  - A pop on a full FIFO raises in_ready on the next cycle, never combinationally in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states IDLE, SHIFT, GAP:
  - IDLE: if fifo_level != 0, pop the head into the DATA_W-bit shift register and go to SHIFT. Otherwise stay in IDLE with all serial outputs at 0.
  - SHIFT:
    - Each bit lasts 2*CLK_DIV cycles: sclk is low for the first CLK_DIV cycles and high for the last CLK_DIV cycles.
    - sdata changes only at bit-period start, i.e. on sclk falling or at frame start, so the receiver samples on the sclk rising edge.
    - sfs = 1 for exactly the first bit period.
    - After the last bit period (DATA_W bits, or DATA_W+1 with the optional feature), go to GAP.
  - GAP: lasts 2*CLK_DIV cycles with sclk = 0, sdata = 0, sfs = 0, then returns to IDLE. Frames are therefore always separated by at least one idle bit period plus one IDLE cycle.
- busy is 1 from the cycle SHIFT is entered through the last GAP cycle.
- Latency with an empty FIFO and the FSM in IDLE:
  - Handshake at edge N: the sample is in the FIFO at N+1 (fifo_level = 1).
  - IDLE pops at N+1.
  - At N+2: sdata = MSB, sfs = 1, busy = 1.
- Frame duration is 2*CLK_DIV*DATA_W cycles of SHIFT plus 2*CLK_DIV cycles of GAP.
- No arithmetic is applied to samples: bits are sent verbatim. The sign/format interpretation belongs to the receiver.

Optional Feature:
- Macro: WYJSCIA_TX_PARITY_EN.
- Defined:
  - One extra bit period follows the LSB carrying even parity (XOR of all DATA_W data bits).
  - sfs behaviour is unchanged.
  - The frame becomes 2*CLK_DIV*(DATA_W+1) SHIFT cycles.
- Undefined: no parity bit; frames carry exactly DATA_W bits.

Test Plan:
- Single sample, defaults: push 24'h800000 at edge N →
  - sfs = 1 on cycles N+2..N+9.
  - sdata = 1 for the first bit period, then 0 for the 23 following bit periods.
  - busy high for 192+8 cycles.
  - fifo_level returns to 0 at N+2.
- Backpressure: in_valid held high with distinct samples every cycle from idle →
  - exactly 5 handshakes accepted (1 popped + 4 buffered), then in_ready = 0 and fifo_level = 4.
  - in_ready returns 1 one cycle after the next pop.
  - All 5 frames are sent in push order.
- Sample 24'h000000 followed by 24'hFFFFFF →
  - first frame: sdata constant 0 with sfs pulsed.
  - second frame: sdata constant 1.
  - the two frames are separated by a ≥8-cycle GAP with sclk = 0.
- Parity (macro defined): 24'h400000 (0.5) → 25th bit = 1; 24'hC00000 → 25th bit = 0.
- Reset mid-frame: assert rst for 1 cycle during bit 10 with 3 samples queued →
  - next cycle: sclk = sdata = sfs = busy = 0 and fifo_level = 0.
  - no further frames are sent until a new push.
- CLK_DIV = 1: push 24'hA5A5A5 → sclk toggles every cycle and the sdata pattern 101001011010010110100101 spans 48 cycles.

Source files
------------

// File: rtl/wyjscia_tx.sv
// Serial transmitter: buffers DATA_W-bit samples in a small FIFO and shifts each one out MSB-first on sclk/sdata/sfs.
// Define WYJSCIA_TX_PARITY_EN to append an even-parity bit after the LSB of every frame.
module wyjscia_tx #(
  parameter int DATA_W     = 24,
  parameter int FIFO_DEPTH = 4,
  parameter int CLK_DIV    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_W-1:0]             in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          sclk,
  output logic                          sdata,
  output logic                          sfs,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
`ifdef WYJSCIA_TX_PARITY_EN
  localparam int NBITS = DATA_W + 1;
`else
  localparam int NBITS = DATA_W;
`endif
  localparam int CNT_W = $clog2(2 * CLK_DIV);
  localparam int BIT_W = $clog2(NBITS);

  localparam logic [CNT_W-1:0] PH_LAST  = CNT_W'(2 * CLK_DIV - 1);
  localparam logic [CNT_W-1:0] PH_HIGH  = CNT_W'(CLK_DIV);
  localparam logic [CNT_W-1:0] PH_ONE   = CNT_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_e;

  // ---------------- FIFO ----------------
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [DATA_W-1:0] head;
  logic              push, pop;

  // Gated by rst so nothing is accepted while the block is being cleared.
  assign in_ready = ~rst & (level_q != LVL_FULL);
  assign push     = in_valid & in_ready;
  assign head     = mem_q[rd_ptr_q];

  // NOTE: sample storage is deliberately not reset; the level counter alone defines which entries are valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      level_q <= level_d;
    end
  end

  // ---------------- Serial framer ----------------
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  ph_q, ph_d;
  logic [BIT_W-1:0]  bit_q, bit_d;
  logic [DATA_W-2:0] shreg_q, shreg_d;   // bits still to send after the one on sdata
  logic              sclk_q, sclk_d;
  logic              sdata_q, sdata_d;
  logic              sfs_q, sfs_d;
  logic              busy_q, busy_d;
`ifdef WYJSCIA_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ph_q    <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      sclk_q  <= 1'b0;
      sdata_q <= 1'b0;
      sfs_q   <= 1'b0;
      busy_q  <= 1'b0;
`ifdef WYJSCIA_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      sclk_q  <= sclk_d;
      sdata_q <= sdata_d;
      sfs_q   <= sfs_d;
      busy_q  <= busy_d;
`ifdef WYJSCIA_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    sclk_d  = 1'b0;
    sdata_d = 1'b0;
    sfs_d   = 1'b0;
    busy_d  = 1'b0;
    pop     = 1'b0;
`ifdef WYJSCIA_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (level_q != '0) begin
          pop     = 1'b1;
          shreg_d = head[DATA_W-2:0];
          sdata_d = head[DATA_W-1];
          sfs_d   = 1'b1;
          busy_d  = 1'b1;
          ph_d    = '0;
          bit_d   = '0;
          state_d = ST_SHIFT;
`ifdef WYJSCIA_TX_PARITY_EN
          par_d   = ^head;
`endif
        end
      end
      ST_SHIFT: begin
        busy_d = 1'b1;
        if (ph_q == PH_LAST) begin
          // Bit period ends: either advance to the next bit or drop into the gap.
          ph_d = '0;
          if (bit_q == BIT_LAST) begin
            state_d = ST_GAP;
          end else begin
            bit_d   = bit_q + BIT_ONE;
            sdata_d = shreg_q[DATA_W-2];
            shreg_d = {shreg_q[DATA_W-3:0], 1'b0};
`ifdef WYJSCIA_TX_PARITY_EN
            if (bit_q == BIT_W'(DATA_W - 1)) sdata_d = par_q;
`endif
          end
        end else begin
          ph_d    = ph_q + PH_ONE;
          sclk_d  = (ph_d >= PH_HIGH);
          sdata_d = sdata_q;
          sfs_d   = sfs_q;
        end
      end
      ST_GAP: begin
        busy_d = 1'b1;
        if (ph_q == PH_LAST) begin
          ph_d    = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          ph_d = ph_q + PH_ONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign sclk       = sclk_q;
  assign sdata      = sdata_q;
  assign sfs        = sfs_q;
  assign busy       = busy_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_wyjscia_tx.sv
// Directed bench for wyjscia_tx: default instance (CLK_DIV=4) plus a CLK_DIV=1 instance.
// Frame expectations follow WYJSCIA_TX_PARITY_EN when it is defined.
module tb_wyjscia_tx;

  localparam int DATA_W = 24;
  localparam int DIV0   = 4;
  localparam int DIV1   = 1;
`ifdef WYJSCIA_TX_PARITY_EN
  localparam int NB = DATA_W + 1;
`else
  localparam int NB = DATA_W;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [DATA_W-1:0] in_data0, in_data1;
  logic              in_valid0, in_valid1;
  logic              in_ready0, in_ready1;
  logic              sclk0, sdata0, sfs0, busy0;
  logic              sclk1, sdata1, sfs1, busy1;
  logic [2:0]        level0, level1;

  wyjscia_tx #(.DATA_W(DATA_W), .FIFO_DEPTH(4), .CLK_DIV(DIV0)) dut0 (
    .clk(clk), .rst(rst), .in_data(in_data0), .in_valid(in_valid0), .in_ready(in_ready0),
    .sclk(sclk0), .sdata(sdata0), .sfs(sfs0), .busy(busy0), .fifo_level(level0)
  );

  wyjscia_tx #(.DATA_W(DATA_W), .FIFO_DEPTH(4), .CLK_DIV(DIV1)) dut1 (
    .clk(clk), .rst(rst), .in_data(in_data1), .in_valid(in_valid1), .in_ready(in_ready1),
    .sclk(sclk1), .sdata(sdata1), .sfs(sfs1), .busy(busy1), .fifo_level(level1)
  );

  int n_checks = 0;
  int n_errors = 0;

  logic [DATA_W-1:0] bp [6] = '{24'h123456, 24'hABCDEF, 24'h0F0F0F, 24'h5A5A5A, 24'h800001, 24'h7FFFFF};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [DATA_W-1:0] s, input int b);
    if (b < DATA_W) return s[DATA_W-1-b];
    return ^s;
  endfunction

  // Entered at the negedge of frame cycle 'start'; returns at the negedge of the IDLE cycle after the gap.
  task automatic check_frame(input int which, input logic [DATA_W-1:0] s, input int start, input string tag);
    int div, len;
    int m_sclk, m_sdata, m_sfs, m_busy, m_gap;
    logic [3:0] o;
    div = (which != 0) ? DIV1 : DIV0;
    len = NB * 2 * div;
    m_sclk = 0; m_sdata = 0; m_sfs = 0; m_busy = 0; m_gap = 0;
    for (int c = start; c < len; c++) begin
      int b, ph;
      b  = c / (2 * div);
      ph = c % (2 * div);
      o  = (which != 0) ? {sclk1, sdata1, sfs1, busy1} : {sclk0, sdata0, sfs0, busy0};
      if (o[3] !== (ph >= div)) m_sclk++;
      if (o[2] !== exp_bit(s, b)) m_sdata++;
      if (o[1] !== (b == 0)) m_sfs++;
      if (o[0] !== 1'b1) m_busy++;
      @(negedge clk);
    end
    for (int g = 0; g < 2 * div; g++) begin
      o = (which != 0) ? {sclk1, sdata1, sfs1, busy1} : {sclk0, sdata0, sfs0, busy0};
      if (o !== 4'b0001) m_gap++;
      @(negedge clk);
    end
    check({tag, " sclk errs"},  m_sclk,  0);
    check({tag, " sdata errs"}, m_sdata, 0);
    check({tag, " sfs errs"},   m_sfs,   0);
    check({tag, " busy errs"},  m_busy,  0);
    check({tag, " gap errs"},   m_gap,   0);
    check({tag, " idle busy"},  (which != 0) ? busy1 : busy0, 0);
  endtask

  initial begin
    int k, p, cnt;
    rst = 1'b1;
    in_valid0 = 1'b0; in_data0 = '0;
    in_valid1 = 1'b0; in_data1 = '0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst in_ready", in_ready0, 0);
    check("rst outputs",  {sclk0, sdata0, sfs0, busy0}, 0);
    check("rst level",    level0, 0);
    check("rst in_ready1", in_ready1, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post-rst in_ready", in_ready0, 1);

    // Single sample 0x800000
    in_valid0 = 1'b1; in_data0 = 24'h800000;
    @(negedge clk);
    in_valid0 = 1'b0;
    check("single level N+1", level0, 1);
    check("single busy N+1",  busy0, 0);
    @(negedge clk);
    check("single level N+2", level0, 0);
    check_frame(0, 24'h800000, 0, "single");

    // All-zeros then all-ones back to back
    in_valid0 = 1'b1; in_data0 = 24'h000000;
    @(negedge clk);
    in_data0 = 24'hFFFFFF;
    @(negedge clk);
    in_valid0 = 1'b0;
    check_frame(0, 24'h000000, 0, "zeros");
    @(negedge clk);
    check_frame(0, 24'hFFFFFF, 0, "ones");

    // Backpressure: valid held high with a new sample each cycle
    k = 0; p = 0;
    in_valid0 = 1'b1;
    for (int c = 0; c < 10; c++) begin
      in_data0 = bp[k];
      if (!in_ready0) break;
      @(posedge clk);
      k++; p++;
      @(negedge clk);
    end
    in_valid0 = 1'b0;
    check("bp accepted", k, 5);
    check("bp level full", level0, 4);
    check("bp ready low", in_ready0, 0);
    check_frame(0, bp[0], (p >= 2) ? p - 2 : 0, "bp0");
    check("bp ready before pop", in_ready0, 0);
    @(negedge clk);
    check("bp ready after pop", in_ready0, 1);
    check("bp level after pop", level0, 3);
    check_frame(0, bp[1], 0, "bp1");
    @(negedge clk);
    check_frame(0, bp[2], 0, "bp2");
    @(negedge clk);
    check_frame(0, bp[3], 0, "bp3");
    @(negedge clk);
    check_frame(0, bp[4], 0, "bp4");
    check("bp drained", level0, 0);

`ifdef WYJSCIA_TX_PARITY_EN
    in_valid0 = 1'b1; in_data0 = 24'h400000;
    @(negedge clk);
    in_valid0 = 1'b0;
    @(negedge clk);
    check_frame(0, 24'h400000, 0, "par 400000");
    in_valid0 = 1'b1; in_data0 = 24'hC00000;
    @(negedge clk);
    in_valid0 = 1'b0;
    @(negedge clk);
    check_frame(0, 24'hC00000, 0, "par C00000");
`endif

    // Reset during bit 10 with three samples queued
    for (int i = 0; i < 4; i++) begin
      in_valid0 = 1'b1; in_data0 = bp[i];
      @(negedge clk);
    end
    in_valid0 = 1'b0;
    check("mid queued", level0, 3);
    repeat (80) @(negedge clk);
    check("mid sfs low in bit 10", sfs0, 0);
    rst = 1'b1;
    @(negedge clk);
    check("mid-rst outputs", {sclk0, sdata0, sfs0, busy0}, 0);
    check("mid-rst level", level0, 0);
    check("mid-rst in_ready", in_ready0, 0);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sfs0 !== 1'b0 || busy0 !== 1'b0 || sclk0 !== 1'b0) cnt++;
    end
    check("no frame after rst", cnt, 0);
    in_valid0 = 1'b1; in_data0 = 24'h3C96E1;
    @(negedge clk);
    in_valid0 = 1'b0;
    @(negedge clk);
    check_frame(0, 24'h3C96E1, 0, "recover");

    // CLK_DIV = 1 instance
    in_valid1 = 1'b1; in_data1 = 24'hA5A5A5;
    @(negedge clk);
    in_valid1 = 1'b0;
    check("div1 level N+1", level1, 1);
    @(negedge clk);
    check_frame(1, 24'hA5A5A5, 0, "div1");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
